// File: rtl/mha_stat_pkg.sv
// rtl/mha_stat_pkg.sv - shared state type, clear defaults and lane helper for the stat vector RAM
package mha_stat_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CLR  = 1'b1
    } state_t;

    localparam int INIT_MAX_W = 64;
    localparam logic [INIT_MAX_W-1:0] LI_INIT_DEF = '0;

    // Most negative two's-complement value of a d_w-bit lane.
    function automatic logic [INIT_MAX_W-1:0] mi_init_def(input int d_w);
        return INIT_MAX_W'(1) << (d_w - 1);
    endfunction

    // Lane 0 sits in the most significant slot of a packed vector.
    function automatic int lane_lsb(input int lane, input int sa_r, input int d_w);
        return (sa_r - 1 - lane) * d_w;
    endfunction

endpackage

// File: rtl/stat_vec_bram_ctrl_if.sv
// rtl/stat_vec_bram_ctrl_if.sv - request/response bundle of the stat vector RAM controller
interface stat_vec_bram_ctrl_if #(
    parameter int D_W    = 16,
    parameter int SA_R   = 16,
    parameter int ADDR_W = 6
);
    logic                  I_CLR;
    logic                  I_REQ_VLD;
    logic                  O_REQ_RDY;
    logic                  I_REQ_WR;
    logic [ADDR_W-1:0]     I_ADDR;
    logic [D_W*SA_R-1:0]   I_WR_MI_VEC;
    logic [D_W*SA_R-1:0]   I_WR_LI_VEC;
    logic                  O_VLD;
    logic [D_W*SA_R-1:0]   O_RD_MI_VEC;
    logic [D_W*SA_R-1:0]   O_RD_LI_VEC;
    logic                  O_BUSY;

    modport master (
        output I_CLR, I_REQ_VLD, I_REQ_WR, I_ADDR, I_WR_MI_VEC, I_WR_LI_VEC,
        input  O_REQ_RDY, O_VLD, O_RD_MI_VEC, O_RD_LI_VEC, O_BUSY
    );

    modport slave (
        input  I_CLR, I_REQ_VLD, I_REQ_WR, I_ADDR, I_WR_MI_VEC, I_WR_LI_VEC,
        output O_REQ_RDY, O_VLD, O_RD_MI_VEC, O_RD_LI_VEC, O_BUSY
    );
endinterface

// File: rtl/stat_sp_ram.sv
// rtl/stat_sp_ram.sv - inferred single-port RAM with a load-gated output register pipeline
module stat_sp_ram #(
    parameter  int W      = 256,
    parameter  int DEPTH  = 64,
    parameter  int RD_LAT = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [W-1:0]      din,
    input  logic [RD_LAT-1:0] ld,
    output logic [W-1:0]      dout
);
    logic [W-1:0] mem  [DEPTH];
    logic [W-1:0] pipe [RD_LAT];

    always_ff @(posedge I_CLK) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // Each stage only loads when a read occupies the stage before it, so dout holds between reads.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                pipe[0] <= mem[addr];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                if (ld[k]) begin
                    pipe[k] <= pipe[k-1];
                end
            end
        end
    end

    assign dout = pipe[RD_LAT-1];
endmodule

// File: rtl/stat_vec_bram_ctrl.sv
// rtl/stat_vec_bram_ctrl.sv - m_i/l_i vector store with in-order requests and a clear sweep
module stat_vec_bram_ctrl
    import mha_stat_pkg::*;
#(
    parameter int             D_W     = 16,
    parameter int             SA_R    = 16,
    parameter int             DEPTH   = 64,
    parameter int             RD_LAT  = 2,
    parameter logic [D_W-1:0] MI_INIT = D_W'(mi_init_def(D_W)),
    parameter logic [D_W-1:0] LI_INIT = D_W'(LI_INIT_DEF)
) (
    input logic                 I_CLK,
    input logic                 I_RST,
    stat_vec_bram_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int VEC_W  = D_W * SA_R;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clr_wr;
    logic              req_rdy, accept;
    logic              st_we;
    logic [ADDR_W-1:0] st_addr;
    logic [VEC_W-1:0]  st_mi, st_li;
    logic [RD_LAT:0]   vpipe;
    logic [VEC_W-1:0]  clr_mi, clr_li;
    logic [VEC_W-1:0]  mi_dout, li_dout;

    for (genvar g = 0; g < SA_R; g++) begin : g_init
        assign clr_mi[lane_lsb(g, SA_R, D_W) +: D_W] = MI_INIT;
        assign clr_li[lane_lsb(g, SA_R, D_W) +: D_W] = LI_INIT;
    end

    assign req_rdy       = (state == S_IDLE) & ~bus.I_CLR;
    assign accept        = bus.I_REQ_VLD & req_rdy;
    assign bus.O_REQ_RDY = req_rdy;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The sweep issues entry 0 in the I_CLR cycle itself, so the port is busy for exactly DEPTH cycles.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_wr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.I_CLR) begin
                    clr_wr      = 1'b1;
                    state_nxt   = S_CLR;
                    clr_cnt_nxt = ADDR_W'(1);
                end
            end
            S_CLR: begin
                clr_wr = 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = S_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // One shared issue stage keeps writes, reads and sweep writes in a single ordered stream.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            st_we <= 1'b0;
            vpipe <= '0;
        end else begin
            st_we <= clr_wr | (accept & bus.I_REQ_WR);
            vpipe <= {vpipe[RD_LAT-1:0], accept & ~bus.I_REQ_WR};
        end
    end

    always_ff @(posedge I_CLK) begin
        st_addr <= clr_wr ? clr_cnt : bus.I_ADDR;
        st_mi   <= clr_wr ? clr_mi  : bus.I_WR_MI_VEC;
        st_li   <= clr_wr ? clr_li  : bus.I_WR_LI_VEC;
    end

    stat_sp_ram #(.W(VEC_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_mi_ram (
        .I_CLK (I_CLK),
        .I_RST (I_RST),
        .we    (st_we),
        .addr  (st_addr),
        .din   (st_mi),
        .ld    (vpipe[RD_LAT-1:0]),
        .dout  (mi_dout)
    );

    stat_sp_ram #(.W(VEC_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) u_li_ram (
        .I_CLK (I_CLK),
        .I_RST (I_RST),
        .we    (st_we),
        .addr  (st_addr),
        .din   (st_li),
        .ld    (vpipe[RD_LAT-1:0]),
        .dout  (li_dout)
    );

    assign bus.O_VLD       = vpipe[RD_LAT];
    assign bus.O_RD_MI_VEC = mi_dout;
    assign bus.O_RD_LI_VEC = li_dout;
    assign bus.O_BUSY      = (state == S_CLR) | (|vpipe[RD_LAT-1:0]);
endmodule

// File: tb/tb_stat_vec_bram_ctrl.sv
// tb/tb_stat_vec_bram_ctrl.sv - scoreboard bench for the stat vector RAM controller
module tb_stat_vec_bram_ctrl;
    localparam int D_W    = 16;
    localparam int SA_R   = 16;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int VEC_W  = D_W * SA_R;
    localparam int TB_MAX = 40;

    typedef logic [VEC_W-1:0] vec_t;
    typedef struct {
        vec_t mi;
        vec_t li;
        int   cyc;
    } exp_t;

    logic I_CLK = 1'b0;
    logic I_RST = 1'b1;

    stat_vec_bram_ctrl_if #(.D_W(D_W), .SA_R(SA_R), .ADDR_W(ADDR_W)) bus ();

    stat_vec_bram_ctrl #(.D_W(D_W), .SA_R(SA_R), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .I_CLK (I_CLK),
        .I_RST (I_RST),
        .bus   (bus)
    );

    always #5 I_CLK = ~I_CLK;

    vec_t mdl_mi [DEPTH];
    vec_t mdl_li [DEPTH];
    exp_t sb [$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   vld_seen = 0;
    vec_t last_mi = '0;
    vec_t last_li = '0;

    function automatic vec_t mk_vec(input int base);
        vec_t v;
        for (int i = 0; i < SA_R; i++) v[(SA_R-1-i)*D_W +: D_W] = D_W'(base + i);
        return v;
    endfunction

    function automatic vec_t fill_vec(input logic [D_W-1:0] lane);
        vec_t v;
        for (int i = 0; i < SA_R; i++) v[(SA_R-1-i)*D_W +: D_W] = lane;
        return v;
    endfunction

    task automatic model_clear(input int upto);
        for (int a = 0; a < upto; a++) begin
            mdl_mi[a] = fill_vec(16'h8000);
            mdl_li[a] = fill_vec(16'h0000);
        end
    endtask

    always @(posedge I_CLK) cyc <= cyc + 1;

    // Scoreboard: every O_VLD pops the oldest expected read; idle cycles must hold the last data.
    always @(posedge I_CLK) begin
        exp_t e;
        #3;
        if (I_RST) begin
            sb.delete();
            last_mi = '0;
            last_li = '0;
        end else if (bus.O_VLD) begin
            vld_seen++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_vld cyc=%0d got O_VLD=1 want 0", cyc);
            end else begin
                e = sb.pop_front();
                tests += 2;
                if (cyc !== e.cyc + RD_LAT + 1) begin
                    fails++;
                    $display("FAIL vld_latency got cyc %0d want %0d", cyc, e.cyc + RD_LAT + 1);
                end
                if (bus.O_RD_MI_VEC !== e.mi) begin
                    fails++;
                    $display("FAIL rd_mi got %h want %h", bus.O_RD_MI_VEC, e.mi);
                end
                if (bus.O_RD_LI_VEC !== e.li) begin
                    fails++;
                    $display("FAIL rd_li got %h want %h", bus.O_RD_LI_VEC, e.li);
                end
                last_mi = e.mi;
                last_li = e.li;
            end
        end else begin
            tests++;
            if (bus.O_RD_MI_VEC !== last_mi || bus.O_RD_LI_VEC !== last_li) begin
                fails++;
                $display("FAIL rd_hold cyc=%0d got %h/%h want %h/%h", cyc,
                         bus.O_RD_MI_VEC, bus.O_RD_LI_VEC, last_mi, last_li);
            end
        end
    end

    // Called just after a falling edge; returns at the next falling edge with the request dropped.
    task automatic drive_req(input bit wr, input int a, input vec_t mi, input vec_t li,
                             input bit exp_acc, output bit acc);
        exp_t e;
        assert (a >= 0 && a < DEPTH) else $error("address %0d outside 0..%0d", a, DEPTH - 1);
        bus.I_REQ_VLD   = 1'b1;
        bus.I_REQ_WR    = wr;
        bus.I_ADDR      = ADDR_W'(a);
        bus.I_WR_MI_VEC = mi;
        bus.I_WR_LI_VEC = li;
        #1;
        acc = bus.O_REQ_RDY;
        if (exp_acc) begin
            if (wr) begin
                mdl_mi[a] = mi;
                mdl_li[a] = li;
            end else begin
                e.mi  = mdl_mi[a];
                e.li  = mdl_li[a];
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
        @(negedge I_CLK);
        bus.I_REQ_VLD = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while ((sb.size() != 0 || bus.O_BUSY) && n < TB_MAX) begin
            @(negedge I_CLK);
            n++;
        end
        ok = (sb.size() == 0);
        sb.delete();
    endtask

    task automatic wait_rdy(output bit ok);
        int n = 0;
        while (!bus.O_REQ_RDY && n < DEPTH + TB_MAX) begin
            @(negedge I_CLK);
            n++;
        end
        ok = bus.O_REQ_RDY;
    endtask

    task automatic test_reset();
        I_RST = 1'b0;
        #1;
        tests += 5;
        if (bus.O_REQ_RDY !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b want 1", bus.O_REQ_RDY); end
        if (bus.O_VLD !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", bus.O_VLD); end
        if (bus.O_BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.O_BUSY); end
        if (bus.O_RD_MI_VEC !== '0) begin fails++; $display("FAIL reset_rd_mi got %h want 0", bus.O_RD_MI_VEC); end
        if (bus.O_RD_LI_VEC !== '0) begin fails++; $display("FAIL reset_rd_li got %h want 0", bus.O_RD_LI_VEC); end
        @(negedge I_CLK);
    endtask

    task automatic test_clear();
        int n = 0;
        bit busy = 1'b0, acc0, acc1, ok;
        bus.I_CLR = 1'b1;
        #1;
        while (!bus.O_REQ_RDY && n < DEPTH + TB_MAX) begin
            n++;
            @(negedge I_CLK);
            bus.I_CLR = 1'b0;
            #1;
            if (n == 1) busy = bus.O_BUSY;
        end
        model_clear(DEPTH);
        tests += 2;
        if (n !== DEPTH) begin fails++; $display("FAIL clear_rdy_low got %0d cycles want %0d", n, DEPTH); end
        if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy got %b want 1", busy); end
        drive_req(1'b0, 0, '0, '0, 1'b1, acc0);
        drive_req(1'b0, DEPTH - 1, '0, '0, 1'b1, acc1);
        drain(ok);
        tests += 2;
        if ({acc0, acc1} !== 2'b11) begin fails++; $display("FAIL clear_read_acc got %b want 11", {acc0, acc1}); end
        if (!ok) begin fails++; $display("FAIL clear_drain got outstanding reads want none"); end
    endtask

    task automatic test_back_to_back();
        bit acc0, acc1, ok;
        int v0 = vld_seen;
        drive_req(1'b1, 5, mk_vec(16'h0100), mk_vec(16'h0010), 1'b1, acc0);
        drive_req(1'b0, 5, '0, '0, 1'b1, acc1);
        drain(ok);
        tests += 3;
        if ({acc0, acc1} !== 2'b11) begin fails++; $display("FAIL b2b_acc got %b want 11", {acc0, acc1}); end
        if (!ok) begin fails++; $display("FAIL b2b_drain got outstanding reads want none"); end
        if (vld_seen - v0 !== 1) begin fails++; $display("FAIL b2b_pulses got %0d want 1", vld_seen - v0); end
    endtask

    task automatic test_streaming();
        bit acc, ok;
        int nacc = 0;
        int v0;
        for (int a = 0; a < 8; a++) drive_req(1'b1, a, mk_vec(16'h1000 + a * 16'h20), mk_vec(16'h2000 + a * 16'h40), 1'b1, acc);
        v0 = vld_seen;
        for (int a = 0; a < 8; a++) begin
            drive_req(1'b0, a, '0, '0, 1'b1, acc);
            nacc += int'(acc);
        end
        drain(ok);
        tests += 3;
        if (nacc !== 8) begin fails++; $display("FAIL stream_rdy got %0d accepted want 8", nacc); end
        if (!ok) begin fails++; $display("FAIL stream_drain got outstanding reads want none"); end
        if (vld_seen - v0 !== 8) begin fails++; $display("FAIL stream_pulses got %0d want 8", vld_seen - v0); end
    endtask

    task automatic test_clr_vs_req();
        bit acc, acc_w, ok_r, ok;
        drive_req(1'b1, 3, mk_vec(16'h3300), mk_vec(16'h0330), 1'b1, acc_w);
        bus.I_CLR = 1'b1;
        drive_req(1'b1, 3, mk_vec(16'h5500), mk_vec(16'h0550), 1'b0, acc);
        bus.I_CLR = 1'b0;
        wait_rdy(ok_r);
        model_clear(DEPTH);
        drive_req(1'b0, 3, '0, '0, 1'b1, acc_w);
        drain(ok);
        tests += 3;
        if (acc !== 1'b0) begin fails++; $display("FAIL clr_prio_acc got %b want 0", acc); end
        if (!ok_r) begin fails++; $display("FAIL clr_prio_sweep got timeout want ready"); end
        if (!ok) begin fails++; $display("FAIL clr_prio_drain got outstanding reads want none"); end
    endtask

    task automatic test_clr_with_reads();
        bit acc, ok_r, ok;
        bit busy;
        drive_req(1'b1, 7, mk_vec(16'h7700), mk_vec(16'h0770), 1'b1, acc);
        drive_req(1'b0, 7, '0, '0, 1'b1, acc);
        bus.I_CLR = 1'b1;
        #1;
        busy = bus.O_BUSY;
        @(negedge I_CLK);
        bus.I_CLR = 1'b0;
        wait_rdy(ok_r);
        model_clear(DEPTH);
        drive_req(1'b0, 7, '0, '0, 1'b1, acc);
        drain(ok);
        tests += 3;
        if (busy !== 1'b1) begin fails++; $display("FAIL inflight_busy got %b want 1", busy); end
        if (!ok_r) begin fails++; $display("FAIL inflight_sweep got timeout want ready"); end
        if (!ok) begin fails++; $display("FAIL inflight_drain got outstanding reads want none"); end
    endtask

    task automatic test_reset_mid_clear();
        bit acc, ok;
        drive_req(1'b1, 9, mk_vec(16'h0900), mk_vec(16'h0090), 1'b1, acc);
        drive_req(1'b1, 10, mk_vec(16'h0A00), mk_vec(16'h00A0), 1'b1, acc);
        drive_req(1'b1, 11, mk_vec(16'h0B00), mk_vec(16'h00B0), 1'b1, acc);
        bus.I_CLR = 1'b1;
        @(negedge I_CLK);
        bus.I_CLR = 1'b0;
        repeat (9) @(negedge I_CLK);
        I_RST = 1'b1;
        @(negedge I_CLK);
        I_RST = 1'b0;
        model_clear(10);
        #1;
        tests += 2;
        if (bus.O_BUSY !== 1'b0) begin fails++; $display("FAIL rst_clr_busy got %b want 0", bus.O_BUSY); end
        if (bus.O_REQ_RDY !== 1'b1) begin fails++; $display("FAIL rst_clr_rdy got %b want 1", bus.O_REQ_RDY); end
        drive_req(1'b0, 9, '0, '0, 1'b1, acc);
        drive_req(1'b0, 10, '0, '0, 1'b1, acc);
        drive_req(1'b0, 11, '0, '0, 1'b1, acc);
        drive_req(1'b0, 0, '0, '0, 1'b1, acc);
        drain(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rst_clr_drain got outstanding reads want none"); end
    endtask

    task automatic test_reset_mid_read();
        bit acc;
        int v0 = vld_seen;
        drive_req(1'b0, 5, '0, '0, 1'b1, acc);
        I_RST = 1'b1;
        @(negedge I_CLK);
        I_RST = 1'b0;
        #1;
        tests += 3;
        if (bus.O_VLD !== 1'b0) begin fails++; $display("FAIL rst_rd_vld got %b want 0", bus.O_VLD); end
        if (bus.O_RD_MI_VEC !== '0) begin fails++; $display("FAIL rst_rd_mi got %h want 0", bus.O_RD_MI_VEC); end
        if (bus.O_RD_LI_VEC !== '0) begin fails++; $display("FAIL rst_rd_li got %h want 0", bus.O_RD_LI_VEC); end
        repeat (RD_LAT + 3) @(negedge I_CLK);
        tests++;
        if (vld_seen - v0 !== 0) begin fails++; $display("FAIL rst_rd_pulses got %0d want 0", vld_seen - v0); end
    endtask

    initial begin
        bus.I_CLR       = 1'b0;
        bus.I_REQ_VLD   = 1'b0;
        bus.I_REQ_WR    = 1'b0;
        bus.I_ADDR      = '0;
        bus.I_WR_MI_VEC = '0;
        bus.I_WR_LI_VEC = '0;
        repeat (3) @(negedge I_CLK);
        test_reset();
        test_clear();
        test_back_to_back();
        test_streaming();
        test_clr_vs_req();
        test_clr_with_reads();
        test_reset_mid_clear();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
